// File: rtl/md_unit.sv
// md_unit: iterative MIPS multiply/divide unit owning the HI/LO registers
module md_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             use_hilo,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic             flush,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             stall_req
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  logic [1:0]         state;
  logic [CNT_W-1:0]   cnt;
  logic               isDiv, negLo, negHi, isSigned, go, fixWrite;
  logic [WIDTH-1:0]   divisor, magA, magB, fixHi, fixLo;
  logic [2*WIDTH-1:0] acc, accNext, prodFix;
  logic [WIDTH:0]     mulSum, divTrial;
  assign busy      = state != IDLE;
  assign stall_req = busy & (use_hilo | start);
  assign isSigned  = ~op[0];
  assign go        = start & ~flush & ~busy;
  assign fixWrite  = state == FIX && !flush;
  assign magA      = (isSigned && src_a[WIDTH-1]) ? -src_a : src_a;
  assign magB      = (isSigned && src_b[WIDTH-1]) ? -src_b : src_b;
  // one radix-2 step: shift-add for multiply, restoring shift-subtract for divide
  always_comb begin
    mulSum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, divisor} : '0);
    divTrial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, divisor};
    accNext  = isDiv ? (divTrial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                        : {divTrial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1})
                     : {mulSum, acc[WIDTH-1:1]};
  end
  // sign correction; a zero divisor leaves the dividend as remainder, only the quotient is forced
  always_comb begin
    prodFix = negLo ? -acc : acc;
    fixLo   = !isDiv ? prodFix[WIDTH-1:0] :
              divisor == '0 ? '1 :
              negLo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    fixHi   = !isDiv ? prodFix[2*WIDTH-1:WIDTH] :
              negHi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end
  // sequencing IDLE -> RUN (WIDTH steps) -> FIX, with flush aborting any busy state
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      isDiv   <= 1'b0;
      negLo   <= 1'b0;
      negHi   <= 1'b0;
      divisor <= '0;
      acc     <= '0;
    end else if (busy && flush) begin
      state <= IDLE;
    end else if (go) begin
      state   <= RUN;
      cnt     <= '0;
      isDiv   <= op[1];
      negLo   <= isSigned & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
      negHi   <= isSigned & src_a[WIDTH-1];
      divisor <= magB;
      acc     <= {{WIDTH{1'b0}}, magA};
    end else if (state == RUN) begin
      acc <= accNext;
      cnt <= cnt + 1'b1;
      if (cnt == CNT_W'(WIDTH - 1)) state <= FIX;
    end else if (state == FIX) begin
      state <= IDLE;
    end
  // HI/LO update from a finished op or from MTHI/MTLO while idle; start takes priority over moves
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hi   <= '0;
      lo   <= '0;
      done <= 1'b0;
    end else begin
      done <= fixWrite;
      if (fixWrite) begin
        hi <= fixHi;
        lo <= fixLo;
      end else if (!busy && !start) begin
        if (mthi) hi <= src_a;
        if (mtlo) lo <= src_a;
      end
    end
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: randomized and directed self-checking bench for md_unit
module tb_md_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        use_hilo = 1'b0;
  logic        mthi = 1'b0;
  logic        mtlo = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] hi, lo;
  logic        busy, done, stall_req;
  int checks = 0;
  int passes = 0;

  md_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .use_hilo(use_hilo), .mthi(mthi), .mtlo(mtlo), .flush(flush),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .stall_req(stall_req)
  );

  always #5 clk = ~clk;

  logic [1:0]  dOp  [9] = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b10, 2'b10, 2'b10, 2'b11, 2'b10};
  logic [31:0] dA   [9] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd100, 32'hFFFFFFF9, 32'd7,
                            32'h12345678, 32'h80000000, 32'h80000000, 32'hFFFFFFF9};
  logic [31:0] dB   [9] = '{32'd5, 32'hFFFFFFFF, 32'd7, 32'd2, 32'hFFFFFFFE,
                            32'd0, 32'hFFFFFFFF, 32'd0, 32'd0};
  logic [63:0] dExp [9] = '{64'hFFFFFFFF_FFFFFFF1, 64'hFFFFFFFE_00000001, 64'h00000002_0000000E,
                            64'hFFFFFFFF_FFFFFFFD, 64'h00000001_FFFFFFFD, 64'h12345678_FFFFFFFF,
                            64'h00000000_80000000, 64'h80000000_FFFFFFFF, 64'hFFFFFFF9_FFFFFFFF};

  // architectural result {hi,lo} computed with plain integer arithmetic
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (o == 2'b00) return sa * sb;
    if (o == 2'b01) return {32'd0, a} * {32'd0, b};
    if (b == 32'd0) return {a, 32'hFFFFFFFF};
    if (o == 2'b11) begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // issue one op at a negedge and wait (bounded) for done; returns cycles to done and busy cycles
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output int busyCycles);
    op = o; src_a = a; src_b = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    busyCycles = 0;
    while (done !== 1'b1 && lat < 100) begin
      busyCycles += int'(busy);
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({hi, lo, busy, done, stall_req} !== 67'd0)
      $display("FAIL reset_state got hi=%h lo=%h busy=%b done=%b stall=%b expected all zero",
               hi, lo, busy, done, stall_req);
    else passes++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int seen;
    src_a = 32'h5A5A5A5A; mthi = 1'b1; mtlo = 1'b1;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    checks++;
    if ({hi, lo} !== {2{32'h5A5A5A5A}}) $display("FAIL mt_both got %h expected %h", {hi, lo}, {2{32'h5A5A5A5A}});
    else passes++;
    op = 2'b01; src_a = 32'hFFFFFFFF; src_b = 32'hFFFFFFFF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({hi, lo, busy, done} !== 66'd0)
      $display("FAIL reset_mid_op got hi=%h lo=%h busy=%b done=%b expected all zero", hi, lo, busy, done);
    else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      seen += int'(done);
    end
    checks++;
    if (seen != 0 || busy !== 1'b0) $display("FAIL reset_no_done got done_count=%0d busy=%b expected 0 0", seen, busy);
    else passes++;
  endtask

  task automatic test_directed();
    int lat, bc;
    for (int i = 0; i < 9; i++) begin
      do_op(dOp[i], dA[i], dB[i], lat, bc);
      checks++;
      if (lat != 34 || bc != 33) $display("FAIL directed_latency[%0d] got lat=%0d busy=%0d expected 34 33", i, lat, bc);
      else passes++;
      checks++;
      if ({hi, lo} !== dExp[i]) $display("FAIL directed_result[%0d] got %h expected %h", i, {hi, lo}, dExp[i]);
      else passes++;
    end
  endtask

  task automatic test_random();
    int lat, bc, mode;
    logic [1:0] o;
    logic [31:0] a, b;
    logic [63:0] exp;
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      mode = $urandom_range(0, 3);
      a = $urandom;
      b = $urandom;
      if (mode == 0) begin
        a = a[7:0] - 32'd128;
        b = b[3:0] - 32'd8;
      end else if (mode == 1) b = 32'd0;
      exp = model(o, a, b);
      do_op(o, a, b, lat, bc);
      checks++;
      if (lat != 34 || {hi, lo} !== exp)
        $display("FAIL random[%0d] op=%0d a=%h b=%h got lat=%0d %h expected 34 %h", i, o, a, b, lat, {hi, lo}, exp);
      else passes++;
    end
  endtask

  task automatic test_hazard();
    logic [63:0] exp;
    exp = model(2'b00, 32'h00001234, 32'hFFFF5678);
    op = 2'b00; src_a = 32'h00001234; src_b = 32'hFFFF5678; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= 34; k++) begin
      use_hilo = k >= 5;
      start = k == 10;
      if (k == 10) begin
        op = 2'b11; src_a = 32'd9; src_b = 32'd3;
      end
      #1;
      checks++;
      if (stall_req !== (k >= 5 && k <= 33)) $display("FAIL stall_req[%0d] got %b expected %b", k, stall_req, k >= 5 && k <= 33);
      else passes++;
      if (k < 34) @(negedge clk);
    end
    checks++;
    if (done !== 1'b1 || {hi, lo} !== exp) $display("FAIL hazard_result got done=%b %h expected 1 %h", done, {hi, lo}, exp);
    else passes++;
    use_hilo = 1'b0;
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) $display("FAIL start_while_busy got done=%b busy=%b expected 0 0", done, busy);
    else passes++;
  endtask

  task automatic test_mt();
    int lat, bc;
    src_a = 32'h11111111; mthi = 1'b1;
    @(negedge clk);
    mthi = 1'b0; src_a = 32'h22222222; mtlo = 1'b1;
    #1;
    checks++;
    if (hi !== 32'h11111111) $display("FAIL mthi got %h expected %h", hi, 32'h11111111);
    else passes++;
    @(negedge clk);
    mtlo = 1'b0;
    checks++;
    if ({hi, lo} !== {32'h11111111, 32'h22222222}) $display("FAIL mtlo got %h expected %h", {hi, lo}, {32'h11111111, 32'h22222222});
    else passes++;
    op = 2'b11; src_a = 32'd100; src_b = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    src_a = 32'hAAAA5555; mtlo = 1'b1;
    @(negedge clk);
    mtlo = 1'b0;
    checks++;
    if (lo !== 32'h22222222) $display("FAIL mtlo_busy got %h expected %h", lo, 32'h22222222);
    else passes++;
    lat = 0;
    while (done !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if ({hi, lo} !== {32'd2, 32'd14}) $display("FAIL mtlo_busy_result got %h expected %h", {hi, lo}, {32'd2, 32'd14});
    else passes++;
    op = 2'b01; src_a = 32'hDEADBEEF; src_b = 32'd3; start = 1'b1; mthi = 1'b1;
    @(negedge clk);
    start = 1'b0; mthi = 1'b0; flush = 1'b1;
    checks++;
    if (busy !== 1'b1) $display("FAIL start_over_mthi got busy=%b expected 1", busy);
    else passes++;
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if (busy !== 1'b0 || {hi, lo} !== {32'd2, 32'd14})
      $display("FAIL mthi_dropped got busy=%b %h expected 0 %h", busy, {hi, lo}, {32'd2, 32'd14});
    else passes++;
    do_op(2'b10, 32'd50, 32'd5, lat, bc);
    checks++;
    if ({hi, lo} !== {32'd0, 32'd10}) $display("FAIL op_after_flush got %h expected %h", {hi, lo}, {32'd0, 32'd10});
    else passes++;
  endtask

  task automatic test_flush();
    int seen;
    src_a = 32'h0F0F0F0F; mthi = 1'b1;
    @(negedge clk);
    mthi = 1'b0; src_a = 32'hF0F0F0F0; mtlo = 1'b1;
    @(negedge clk);
    mtlo = 1'b0;
    foreach (dA[j]) begin
      if (j > 1) break;
      op = 2'b00; src_a = $urandom; src_b = $urandom; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (j == 0 ? 19 : 32) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      checks++;
      if (busy !== 1'b0) $display("FAIL flush_busy[%0d] got %b expected 0", j, busy);
      else passes++;
      seen = 0;
      repeat (40) begin
        @(negedge clk);
        seen += int'(done);
      end
      checks++;
      if (seen != 0 || {hi, lo} !== {32'h0F0F0F0F, 32'hF0F0F0F0})
        $display("FAIL flush_keep[%0d] got done_count=%0d %h expected 0 %h", j, seen, {hi, lo}, {32'h0F0F0F0F, 32'hF0F0F0F0});
      else passes++;
    end
    op = 2'b10; src_a = 32'd9; src_b = 32'd2; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    checks++;
    if (busy !== 1'b0) $display("FAIL flush_start_idle got busy=%b expected 0", busy);
    else passes++;
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    logic [1:0] o;
    logic [31:0] a, b;
    logic [63:0] exp;
    for (int i = 0; i < 6; i++) begin
      o = 2'(i % 4);
      a = $urandom;
      b = $urandom_range(1, 1000);
      exp = model(o, a, b);
      do_op(o, a, b, lat, bc);
      checks++;
      if (lat != 34 || {hi, lo} !== exp) $display("FAIL back_to_back[%0d] got lat=%0d %h expected 34 %h", i, lat, {hi, lo}, exp);
      else passes++;
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) $display("FAIL done_pulse got %b expected 0", done);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_directed();
    test_random();
    test_hazard();
    test_mt();
    test_flush();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
